// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the MIPS ALU datapath with imem handshake and sticky fault.
// Define MIPS_CTRL_RETIRE_CNT_EN to build the retired-instruction counter; otherwise retired reads 0.
module mips_multicycle_ctrl #(
  parameter int unsigned     PC_W          = 32,
  parameter logic [PC_W-1:0] RESET_PC      = '0,
  parameter int unsigned     PC_STEP       = 4,
  parameter int unsigned     CNT_W         = 16,
  parameter int unsigned     FETCH_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic             imem_ack,
  input  logic [31:0]      instr,
  input  logic             dec_writeenable,
  input  logic             dec_except,
  output logic             imem_req,
  output logic [PC_W-1:0]  pc,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic             alu_latch,
  output logic             rf_we,
  output logic             busy,
  output logic             fault,
  output logic             fault_cause,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned   TO_W    = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q;
  logic [31:0]       ir_q;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              fault_cause_q, cause_d;
  logic              ir_load, retire;
  logic              imem_req_q, alu_latch_q, wb_q, busy_q, fault_q;

  // Next-state decode; the timeout counter only advances on FETCH cycles without an ack.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = '0;
    cause_d  = fault_cause_q;
    ir_load  = 1'b0;
    retire   = 1'b0;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = S_FAULT;
          cause_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_DECODE: begin
        if (dec_except) begin
          state_d = S_FAULT;
          cause_d = 1'b0;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:   state_d = S_WB;
      S_WB: begin
        retire  = 1'b1;
        state_d = stop ? S_IDLE : S_FETCH;
      end
      S_FAULT:  if (start) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, PC/IR and Moore output flags (flags registered from the next state).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      ir_q          <= '0;
      to_cnt_q      <= '0;
      fault_cause_q <= 1'b0;
      imem_req_q    <= 1'b0;
      alu_latch_q   <= 1'b0;
      wb_q          <= 1'b0;
      busy_q        <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      fault_cause_q <= cause_d;
      if (ir_load) ir_q <= instr;
      if (retire)  pc_q <= pc_q + PC_W'(PC_STEP);
      imem_req_q    <= (state_d == S_FETCH);
      alu_latch_q   <= (state_d == S_EXEC);
      wb_q          <= (state_d == S_WB);
      busy_q        <= (state_d != S_IDLE) && (state_d != S_FAULT);
      fault_q       <= (state_d == S_FAULT);
    end
  end

`ifdef MIPS_CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q;

  // Saturating retired-instruction counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
    end else if (retire && !(&retired_q)) begin
      retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

  // IR[25:6] is held for the datapath but not consumed by this block.
  logic unused_ir_mid;
  assign unused_ir_mid = ^ir_q[25:6];

  assign imem_req    = imem_req_q;
  assign pc          = pc_q;
  assign opcode      = ir_q[31:26];
  assign funct       = ir_q[5:0];
  assign alu_latch   = alu_latch_q;
  assign rf_we       = wb_q & dec_writeenable;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;

endmodule
